// File: rtl/wb_dmem_reader.sv
// Wishbone read-back slave for dmem port 1. It shares the port with the core load path.
// The core has priority, and a bounded wait counter forces a stalled Wishbone read through.
module wb_dmem_reader #(
   parameter logic [31:0] BASE_ADDR = 32'h3010_0000,
   parameter logic [31:0] ADDR_MASK = 32'hFFFF_FC00,
   parameter int unsigned STALL_MAX = 4
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic        core_rd_en,
   input  logic [7:0]  core_rd_addr,
   output logic [31:0] core_rd_data,
   output logic        core_rd_valid,
   output logic        core_stall,
   output logic        sram_csb1,
   output logic [7:0]  sram_addr1,
   input  logic [31:0] sram_dout1
);

   localparam logic [3:0] STALL_LIM = 4'(STALL_MAX);

   typedef enum logic [1:0] {IDLE, REQ, READ, ACK} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  addr_q, addr_d;
   logic [31:0] dat_q, dat_d;
   logic        vld_q;
   logic        hit, grant_wb;

   assign hit      = wbs_stb_i & wbs_cyc_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
   assign grant_wb = (state_q == REQ) & (~core_rd_en | (cnt_q == STALL_LIM));

   assign sram_csb1     = grant_wb ? 1'b0 : ~core_rd_en;
   assign sram_addr1    = grant_wb ? addr_q : core_rd_addr;
   assign core_stall    = core_rd_en & grant_wb;
   assign core_rd_data  = sram_dout1;
   assign core_rd_valid = vld_q;
   assign wbs_ack_o     = (state_q == ACK);
   assign wbs_dat_o     = dat_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      dat_d   = dat_q;
      case (state_q)
         IDLE: begin
            if (hit) begin
               if (wbs_we_i) begin
                  state_d = ACK;
               end else begin
                  addr_d  = wbs_adr_i[9:2];
                  cnt_d   = 4'd0;
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            // An abort wins over a grant; a port-1 read already issued is harmless.
            if (!wbs_cyc_i)    state_d = IDLE;
            else if (grant_wb) state_d = READ;
            else               cnt_d   = cnt_q + 4'd1;
         end
         READ: begin
            if (!wbs_cyc_i) begin
               state_d = IDLE;
            end else begin
               dat_d   = sram_dout1;
               state_d = ACK;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 8'd0;
         dat_q   <= 32'd0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         dat_q   <= dat_d;
         vld_q   <= core_rd_en & ~core_stall;
      end
   end

endmodule

// File: tb/tb_wb_dmem_reader.sv
// Directed bench for wb_dmem_reader: an SRAM model, a timestamp-based transaction model checked
// every cycle, and literal latency/data expectations in the stimulus.
module tb_wb_dmem_reader;

   localparam logic [31:0] BASE = 32'h3010_0000;
   localparam int          SMAX = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [31:0] adr = 32'd0;
   logic        ack;
   logic [31:0] dat;
   logic        core_hold = 1'b0, alt_on = 1'b0, alt_ph = 1'b0;
   logic        core_en;
   logic [7:0]  core_addr = 8'd0;
   logic [31:0] core_data;
   logic        core_valid, core_stall;
   logic        csb;
   logic [7:0]  saddr;
   logic [31:0] dout = 32'd0;
   logic [31:0] mem [256];

   int nvec = 0, nerr = 0;
   int n_ack = 0, n_stall = 0;

   assign core_en = core_hold | (alt_on & alt_ph);

   wb_dmem_reader #(.BASE_ADDR(BASE), .ADDR_MASK(32'hFFFF_FC00), .STALL_MAX(SMAX)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
      .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat), .core_rd_en(core_en),
      .core_rd_addr(core_addr), .core_rd_data(core_data), .core_rd_valid(core_valid),
      .core_stall(core_stall), .sram_csb1(csb), .sram_addr1(saddr), .sram_dout1(dout)
   );

   always #5 clk = ~clk;

   // Port-1 SRAM: data appears the cycle after the access edge.
   always @(posedge clk) if (!csb) dout <= mem[saddr];
   always @(posedge clk) alt_ph <= ~alt_ph;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction model: one pending Wishbone access tracked by cycle stamps.
   int          k = 0, waits = 0, ack_at = -1, grant_at = -10, free_from = 0;
   bit          armed = 0, pend = 0, granted = 0, ack_rd = 0, pv = 0, gnow;
   logic [7:0]  word = 8'd0, pca = 8'd0;
   logic [31:0] mdat = 32'd0;

   always @(negedge clk) begin
      k++;
      gnow = pend && !granted && (!core_en || waits == SMAX);
      if (armed) begin
         chk("csb", {31'd0, csb}, {31'd0, gnow ? 1'b0 : ~core_en});
         if (!csb) chk("sram_addr", {24'd0, saddr}, {24'd0, gnow ? word : core_addr});
         chk("core_stall", {31'd0, core_stall}, {31'd0, core_en & gnow});
         if (k == ack_at && ack_rd) mdat = mem[word];
         chk("ack", {31'd0, ack}, {31'd0, k == ack_at});
         chk("wb_dat", dat, mdat);
         chk("core_valid", {31'd0, core_valid}, {31'd0, pv});
         if (pv) chk("core_data", core_data, mem[pca]);
         n_ack   += int'(ack);
         n_stall += int'(core_stall);
      end
      if (rst) begin
         pend = 0; granted = 0; ack_at = -1; free_from = k + 1; mdat = 32'd0; pv = 0; armed = 1;
      end else begin
         pv  = core_en && !gnow;
         pca = core_addr;
         if (k == ack_at) pend = 0;
         if (pend && !cyc && (!granted || k == grant_at + 1)) begin
            pend = 0; granted = 0; ack_at = -1; free_from = k + 1;
         end else if (gnow) begin
            granted = 1; grant_at = k; ack_at = k + 2; free_from = k + 3;
         end else if (pend && !granted) begin
            waits++;
         end
         if (k >= free_from && !pend && stb && cyc && ((adr & 32'hFFFF_FC00) == BASE)) begin
            if (we) begin
               ack_at = k + 1; ack_rd = 0; free_from = k + 2;
            end else begin
               pend = 1; granted = 0; word = adr[9:2]; waits = 0; ack_rd = 1; free_from = 1 << 30;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Issue one access, return cycles from request edge to ack (0 on timeout).
   task automatic wb_xfer(input logic [31:0] a, input logic w, output int lat);
      stb = 1'b1; cyc = 1'b1; we = w; adr = a;
      tick();
      lat = 0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (ack) begin lat = n; break; end
         @(posedge clk); #1;
      end
      if (lat == 0) chk("ack_timeout", 32'd0, 32'd1);
      tick();
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
   endtask

   int lat, a0, s0;

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | (i * 32'h0001_0101);
      mem[5] = 32'hDEAD_BEEF;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ack", {31'd0, ack}, 32'd0);
      chk("rst_dat", dat, 32'd0);
      chk("rst_valid", {31'd0, core_valid}, 32'd0);
      chk("rst_csb", {31'd0, csb}, 32'd1);
      tick();

      // Uncontended read of word 5.
      a0 = n_ack;
      wb_xfer(BASE + 32'h14, 1'b0, lat);
      chk("rd5_lat", lat, 3);
      chk("rd5_dat", dat, 32'hDEAD_BEEF);
      repeat (3) tick();
      chk("rd5_one_ack", n_ack - a0, 1);

      // Discarded write, then read back word 2.
      wb_xfer(BASE + 32'h8, 1'b1, lat);
      chk("wr_lat", lat, 1);
      chk("wr_dat_kept", dat, 32'hDEAD_BEEF);
      wb_xfer(BASE + 32'h8, 1'b0, lat);
      chk("rd2_dat", dat, 32'hA502_0202);

      // Outside the window, with some core traffic going on.
      a0 = n_ack;
      core_addr = 8'd11; alt_on = 1'b1;
      stb = 1'b1; cyc = 1'b1; adr = BASE + 32'h400;
      repeat (10) tick();
      stb = 1'b0; cyc = 1'b0; alt_on = 1'b0;
      tick();
      chk("oow_no_ack", n_ack - a0, 0);

      // Continuous core load: forced through after SMAX waits.
      core_hold = 1'b1; core_addr = 8'd20;
      s0 = n_stall;
      wb_xfer(BASE + 32'h1C, 1'b0, lat);
      chk("rd7_lat", lat, 7);
      chk("rd7_dat", dat, 32'hA507_0707);
      chk("rd7_one_stall", n_stall - s0, 1);
      core_hold = 1'b0;

      // Alternating core loads of word 3: Wishbone slips into an idle cycle.
      core_addr = 8'd3; alt_on = 1'b1;
      s0 = n_stall;
      wb_xfer(BASE + 32'h24, 1'b0, lat);
      chk("rd9_lat_ok", {31'd0, lat == 3 || lat == 4}, 32'd1);
      chk("rd9_dat", dat, 32'hA509_0909);
      chk("rd9_no_stall", n_stall - s0, 0);
      repeat (4) tick();
      alt_on = 1'b0;

      // Abort while waiting in REQ.
      core_hold = 1'b1;
      a0 = n_ack;
      stb = 1'b1; cyc = 1'b1; adr = BASE + 32'h10;
      tick(); tick();
      stb = 1'b0; cyc = 1'b0;
      repeat (6) tick();
      chk("abort_no_ack", n_ack - a0, 0);
      core_hold = 1'b0;
      wb_xfer(BASE + 32'h14, 1'b0, lat);
      chk("post_abort_lat", lat, 3);

      // Reset while in READ.
      a0 = n_ack;
      stb = 1'b1; cyc = 1'b1; adr = BASE + 32'h30;
      tick(); tick();
      rst = 1'b1; stb = 1'b0; cyc = 1'b0;
      tick();
      rst = 1'b0;
      repeat (4) tick();
      chk("rst_mid_no_ack", n_ack - a0, 0);
      chk("rst_mid_dat", dat, 32'd0);
      wb_xfer(BASE + 32'h30, 1'b0, lat);
      chk("post_rst_lat", lat, 3);
      chk("post_rst_dat", dat, 32'hA50C_0C0C);

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/wb_dmem_reader.md
# wb_dmem_reader

Wishbone read-back slave for the data-memory SRAM. It lets the management SoC read the `dmem` macro (`sky130_sram_1kbyte_1rw1r_32x256_8`) through its read-only port 1. It shares that port with the processor core's load path, so it is the read-side counterpart of the existing Wishbone write path into `imem`. Core and Wishbone requests are arbitrated with core priority, plus a bounded starvation guard for the Wishbone side.

## Interface
Parameters:
- BASE_ADDR, 32'h3010_0000, Wishbone byte address of dmem word 0
- ADDR_MASK, 32'hFFFF_FC00, compare mask for the window decode (1 KB window)
- STALL_MAX, 4, maximum cycles a Wishbone read waits on core traffic before being forced through (range 1..15)

Ports:
- wb_clk_i  in  1  single clock for the block and SRAM port 1
- wb_rst_i  in  1  synchronous, active-high reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  Wishbone write enable
- wbs_adr_i  in  32  Wishbone byte address
- wbs_ack_o  out  1  Wishbone acknowledge, registered
- wbs_dat_o  out  32  Wishbone read data, registered
- core_rd_en  in  1  core load request, active-high
- core_rd_addr  in  8  core word address
- core_rd_data  out  32  core load data, combinational from sram_dout1
- core_rd_valid  out  1  core_rd_data is valid this cycle
- core_stall  out  1  core request not granted this cycle; the core holds the request
- sram_csb1  out  1  SRAM port-1 chip select, active-low
- sram_addr1  out  8  SRAM port-1 word address
- sram_dout1  in  32  SRAM port-1 data, valid the cycle after the access edge

## Operation
- Window hit: `wbs_stb_i & wbs_cyc_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR)`. The word address is `wbs_adr_i[9:2]`; bits [1:0] are ignored.
- FSM states: IDLE, REQ, READ, ACK.
  - IDLE: on a hit with `wbs_we_i=1`, go to ACK. The write is discarded and wbs_dat_o is unchanged. On a read hit, latch the word address, clear the wait counter and go to REQ.
  - REQ: the Wishbone side is granted when `core_rd_en=0` or the wait counter equals STALL_MAX. On a grant, go to READ. Otherwise increment the wait counter and stay in REQ.
  - READ: load sram_dout1 into wbs_dat_o, then go to ACK.
  - ACK: `wbs_ack_o=1` for exactly one cycle, then go to IDLE.
- Abort: if `wbs_cyc_i=0` in REQ or READ, return to IDLE with no ack and leave wbs_dat_o unchanged. An SRAM read already issued is harmless.
- Port mux (combinational):
  - grant_wb = (state==REQ) & (core_rd_en==0 | cnt==STALL_MAX)
  - sram_csb1 = grant_wb ? 0 : ~core_rd_en
  - sram_addr1 = grant_wb ? latched address : core_rd_addr
  - core_stall = core_rd_en & grant_wb
- core_rd_valid is a register loaded with `core_rd_en & ~core_stall` each cycle. core_rd_data = sram_dout1 at all times; the core uses it only when core_rd_valid=1.
- A request outside the window is ignored: no ack and no state change.

## Timing
- Reset values: wbs_ack_o=0, wbs_dat_o=0, core_rd_valid=0, FSM in IDLE, wait counter 0. With core_rd_en=0 after reset, sram_csb1=1.
- Reset mid-transaction returns the FSM to IDLE on the next edge; no ack is issued.
- Uncontended read, with the hit sampled at edge T:
  - REQ during cycle T+1, SRAM access edge at T+2
  - READ during T+2, wbs_dat_o valid from edge T+3
  - wbs_ack_o high for cycle T+3
  - Latency: 3 cycles from request to ack.
- Write: hit at edge T, wbs_ack_o high for cycle T+1.
- Contended read: each cycle with core_rd_en=1 in REQ adds one cycle, up to STALL_MAX cycles. In the next cycle the Wishbone side is forced and core_stall=1 for exactly one cycle. Worst-case latency is 3+STALL_MAX cycles.
- Core load: request in cycle C, data and core_rd_valid=1 in cycle C+1. When stalled, the core retries in C+1.
- Back-to-back: a new hit is accepted only in IDLE. The earliest is the cycle after ACK, so the Wishbone side sees one request per 4 cycles.

## Test plan
- Reset, then preload dmem word 5 with 32'hDEAD_BEEF. A Wishbone read at BASE_ADDR+0x14 -> ack 3 cycles after the request, wbs_dat_o=32'hDEAD_BEEF, exactly one ack pulse.
- Wishbone write 32'h1234_5678 to BASE_ADDR+0x8 -> ack one cycle later, then a read of word 2 returns the original contents (write discarded).
- Read at BASE_ADDR+0x400 (outside the window) held for 10 cycles -> no ack, sram_csb1 follows core_rd_en only.
- core_rd_en held at 1 continuously while a Wishbone read of word 7 is pending -> core_stall=1 for exactly one cycle, after STALL_MAX=4 waiting cycles. Ack arrives 7 cycles after the request with word 7 data. core_rd_valid=0 exactly in the cycle following the stall.
- Core loads from word 3 in alternate cycles while the Wishbone side reads word 9 -> the Wishbone read is granted in a core-idle cycle with no core_stall. Every core_rd_valid cycle returns word 3 data.
- Drop wbs_cyc_i while in REQ, or assert wb_rst_i while in READ -> no ack, FSM back in IDLE, and the next read completes normally.
